// File: rtl/out_delta_pkg.sv
// out_delta_pkg: shared definitions for the output-layer error stage and the
// fixed-point multiplier it shares with the weight-update stage.
//   DEF_WIDTH/DEF_FRAC : default Q8.24 word format
//   ONE, SMAX, SMIN    : 1.0 and saturation bounds in the default format
//   state_t            : error-stage FSM states
//   sat_to()           : clamp a wide signed value into a w-bit signed range
package out_delta_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_FRAC  = 24;
  // Working width of sat_to(); covers both WIDTH+1 sums and 2*WIDTH products
  // for any WIDTH up to 64.
  localparam int unsigned SAT_W     = 128;

  localparam logic signed [DEF_WIDTH-1:0] ONE  = 32'sd1 <<< DEF_FRAC;
  localparam logic signed [DEF_WIDTH-1:0] SMAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_WIDTH-1:0] SMIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MUL1 = 2'd2,
    ST_MUL2 = 2'd3
  } state_t;

  // Clamp x into [-2^(w-1), 2^(w-1)-1]; caller truncates the result to w bits.
  function automatic logic signed [SAT_W-1:0] sat_to(
    input logic signed [SAT_W-1:0] x,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/out_delta_fxp_mul.sv
// fxp_mul: combinational signed fixed-point multiply.
// Full 2*WIDTH product, arithmetic shift right by FRAC (rounds toward -inf),
// then saturate to the WIDTH-bit signed range.
//   i_x, i_y : signed WIDTH-bit operands
//   o_z      : saturated signed WIDTH-bit product
module fxp_mul
  import out_delta_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic signed [WIDTH-1:0] i_x,
  input  logic signed [WIDTH-1:0] i_y,
  output logic signed [WIDTH-1:0] o_z
);

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [2*WIDTH-1:0] w_shr;

  assign w_prod = (2*WIDTH)'(i_x) * (2*WIDTH)'(i_y);
  assign w_shr  = w_prod >>> FRAC;
  assign o_z    = WIDTH'(sat_to(SAT_W'(w_shr), WIDTH));

endmodule

// File: rtl/out_delta.sv
// out_delta: output-layer error stage.
// For each neuron k, serially: d_k = (a_k - t_k) * a_k * (1 - a_k), and
// cost = sum (a_k - t_k)^2, all saturating fixed point, through one shared
// fxp_mul. Results are registered and announced by a one-cycle o_valid.
//   clk, rst : clock, synchronous active-high reset
//   i_start  : job request, sampled only while idle
//   i_a, i_t : packed activations / targets, lane k at [k*WIDTH +: WIDTH]
//   o_busy   : high while a job is in progress
//   o_valid  : one-cycle pulse when o_d/o_cost are updated
//   o_d      : packed deltas, same lane packing
//   o_cost   : summed squared error
module out_delta
  import out_delta_pkg::*;
#(
  parameter int unsigned NUM_PCTN = 2,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned FRAC     = DEF_FRAC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [NUM_PCTN*WIDTH-1:0] i_a,
  input  logic [NUM_PCTN*WIDTH-1:0] i_t,
  output logic                      o_busy,
  output logic                      o_valid,
  output logic [NUM_PCTN*WIDTH-1:0] o_d,
  output logic [WIDTH-1:0]          o_cost
);

  localparam int unsigned       KW     = (NUM_PCTN > 1) ? $clog2(NUM_PCTN) : 1;
  localparam logic [KW-1:0]     K_LAST = KW'(NUM_PCTN - 1);
  localparam logic signed [WIDTH:0] ONE_X = (WIDTH+1)'(1) << FRAC;

  state_t r_state;
  state_t w_next;

  logic [KW-1:0]           r_k;
  logic signed [WIDTH-1:0] r_a    [NUM_PCTN];
  logic signed [WIDTH-1:0] r_t    [NUM_PCTN];
  logic signed [WIDTH-1:0] r_dbuf [NUM_PCTN];
  logic signed [WIDTH-1:0] w_dnext[NUM_PCTN];
  logic signed [WIDTH-1:0] r_e, r_s, r_p, r_q, r_acc;
  logic [NUM_PCTN*WIDTH-1:0] r_d;
  logic [WIDTH-1:0]        r_cost;
  logic                    r_valid;

  logic signed [WIDTH-1:0] w_ak, w_tk, w_e, w_s, w_acc;
  logic signed [WIDTH-1:0] w_mx, w_my, w_mz;
  logic signed [WIDTH:0]   w_diff, w_omin, w_accsum;
  logic                    w_last;

  // ---------------- lane arithmetic ----------------
  assign w_ak   = r_a[r_k];
  assign w_tk   = r_t[r_k];
  assign w_diff = $signed({w_ak[WIDTH-1], w_ak}) - $signed({w_tk[WIDTH-1], w_tk});
  assign w_omin = ONE_X - $signed({w_ak[WIDTH-1], w_ak});
  assign w_e    = WIDTH'(sat_to(SAT_W'(w_diff), WIDTH));
  assign w_s    = WIDTH'(sat_to(SAT_W'(w_omin), WIDTH));
  assign w_accsum = $signed({r_acc[WIDTH-1], r_acc}) + $signed({r_q[WIDTH-1], r_q});
  assign w_acc  = WIDTH'(sat_to(SAT_W'(w_accsum), WIDTH));
  assign w_last = (r_k == K_LAST);

  // Single multiplier, time-multiplexed. q = e*e is taken in SUB straight from
  // the combinational e, so each state needs only one product:
  // SUB: q = e*e, MUL1: p = e*a, MUL2: d = p*s.
  always_comb begin
    w_mx = '0;
    w_my = '0;
    case (r_state)
      ST_SUB:  begin w_mx = w_e; w_my = w_e;  end
      ST_MUL1: begin w_mx = r_e; w_my = w_ak; end
      ST_MUL2: begin w_mx = r_p; w_my = r_s;  end
      default: ;
    endcase
  end

  fxp_mul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .i_x (w_mx),
    .i_y (w_my),
    .o_z (w_mz)
  );

  // Delta buffer with the current lane replaced, so the final MUL2 can publish
  // all lanes in the same edge that writes the last one.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PCTN; i++) w_dnext[i] = r_dbuf[i];
    w_dnext[r_k] = w_mz;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_SUB;
      ST_SUB:  w_next = ST_MUL1;
      ST_MUL1: w_next = ST_MUL2;
      ST_MUL2: w_next = w_last ? ST_IDLE : ST_SUB;
      default: w_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_e     <= '0;
      r_s     <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_d     <= '0;
      r_cost  <= '0;
      r_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_PCTN; i++) begin
        r_a[i]    <= '0;
        r_t[i]    <= '0;
        r_dbuf[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            for (int unsigned i = 0; i < NUM_PCTN; i++) begin
              r_a[i] <= i_a[i*WIDTH +: WIDTH];
              r_t[i] <= i_t[i*WIDTH +: WIDTH];
            end
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        ST_SUB: begin
          r_e <= w_e;
          r_s <= w_s;
          r_q <= w_mz;
        end
        ST_MUL1: r_p <= w_mz;
        ST_MUL2: begin
          for (int unsigned i = 0; i < NUM_PCTN; i++) r_dbuf[i] <= w_dnext[i];
          r_acc <= w_acc;
          if (w_last) begin
            for (int unsigned i = 0; i < NUM_PCTN; i++) r_d[i*WIDTH +: WIDTH] <= w_dnext[i];
            r_cost  <= w_acc;
            r_valid <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_valid = r_valid;
  assign o_d     = r_d;
  assign o_cost  = r_cost;

endmodule
